// File: rtl/window_gen_kxk.sv
// KxK sliding-window generator over a raster stream: K-1 circular line buffers,
// coordinate-driven border padding, and a self-flush that emits the trailing edge windows.
module window_gen_kxk_line #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 256,
  parameter int XW     = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [XW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [IMG_W];

  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;

  assign rdata = mem[addr];
endmodule

module window_gen_kxk #(
  parameter int DATA_W = 8,
  parameter int K      = 5,
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sof,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  pad_max,
  output logic                  out_valid,
  output logic [K*K*DATA_W-1:0] out_window,
  output logic                  out_sof,
  output logic                  out_eof
);
  localparam int R  = (K - 1) / 2;
  localparam int D  = R * IMG_W + R;
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int DW = $clog2(D + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  logic [1:0]    state;
  logic [XW-1:0] in_x, out_x, addr;
  logic [YW-1:0] in_y, out_y;
  logic [DW-1:0] fill, flush_cnt;
  logic          pad_sel, start, beat, fire;
  logic [DATA_W-1:0] pix, pad_val;
  logic [K-1:0][K-1:0][DATA_W-1:0] win, win_nxt, win_pad;
  logic [K-1:0][DATA_W-1:0]        col;
  logic [K-2:0][DATA_W-1:0]        lb_rd, lb_wr;

  assign in_ready = (state != FLUSH);
  assign start    = in_valid & in_sof & in_ready;
  assign beat     = start | ((state == RUN) & in_valid) | (state == FLUSH);
  // fill counts beats of the current frame; the window for centre n completes at beat n+D
  assign fire     = beat & ~start & (fill == DW'(D));
  assign addr     = start ? '0 : in_x;
  assign pix      = (state == FLUSH) ? '0 : in_data;
  assign pad_val  = {DATA_W{pad_sel}};

  genvar i;
  generate
    for (i = 0; i < K - 1; i++) begin : g_line
      if (i == 0) begin : g_head
        assign lb_wr[i] = pix;
      end else begin : g_chain
        assign lb_wr[i] = lb_rd[i-1];
      end
      assign col[K-2-i] = lb_rd[i];
      window_gen_kxk_line #(.DATA_W(DATA_W), .IMG_W(IMG_W), .XW(XW)) u_line (
        .clk   (clk),
        .we    (beat),
        .addr  (addr),
        .wdata (lb_wr[i]),
        .rdata (lb_rd[i])
      );
    end
  endgenerate
  assign col[K-1] = pix;

  always_comb begin
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) win_nxt[r][c] = win[r][c+1];
      win_nxt[r][K-1] = col[r];
    end
  end

  // Columns that wrapped from the neighbouring line and rows outside the frame
  // are exactly the out-of-image elements, so masking by centre coordinates suffices.
  always_comb begin
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        win_pad[r][c] = ((int'(out_y) + r < R) || (int'(out_y) + r - R >= IMG_H) ||
                         (int'(out_x) + c < R) || (int'(out_x) + c - R >= IMG_W))
                        ? pad_val : win_nxt[r][c];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_x       <= '0;
      in_y       <= '0;
      out_x      <= '0;
      out_y      <= '0;
      fill       <= '0;
      flush_cnt  <= '0;
      pad_sel    <= 1'b0;
      win        <= '0;
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      out_eof    <= 1'b0;
      out_window <= '0;
    end else begin
      out_valid <= fire;
      out_sof   <= fire && (out_x == '0) && (out_y == '0);
      out_eof   <= fire && (out_x == XW'(IMG_W - 1)) && (out_y == YW'(IMG_H - 1));
      if (fire) begin
        out_window <= win_pad;
        if (out_x == XW'(IMG_W - 1)) begin
          out_x <= '0;
          out_y <= (out_y == YW'(IMG_H - 1)) ? '0 : out_y + 1'b1;
        end else begin
          out_x <= out_x + 1'b1;
        end
      end
      if (beat) win <= win_nxt;
      if (start) begin
        state   <= RUN;
        in_x    <= XW'(1);
        in_y    <= '0;
        fill    <= DW'(1);
        out_x   <= '0;
        out_y   <= '0;
        pad_sel <= pad_max;
      end else if (beat) begin
        if (fill != DW'(D)) fill <= fill + 1'b1;
        in_x <= (in_x == XW'(IMG_W - 1)) ? '0 : in_x + 1'b1;
        if (state == RUN) begin
          if (in_x == XW'(IMG_W - 1)) begin
            if (in_y == YW'(IMG_H - 1)) begin
              state     <= FLUSH;
              flush_cnt <= '0;
            end else begin
              in_y <= in_y + 1'b1;
            end
          end
        end else if (flush_cnt == DW'(D - 1)) begin
          state <= IDLE;
        end else begin
          flush_cnt <= flush_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_window_gen_kxk.sv
// Randomized bench for window_gen_kxk (K=3, 4x4): expected windows come from a
// direct per-pixel model of the frame; a few literal windows pin that model.
module tb_window_gen_kxk;
  localparam int DATA_W = 8;
  localparam int K  = 3;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int R  = (K - 1) / 2;
  localparam int D  = R * W + R;
  localparam int N  = W * H;
  localparam int WW = K * K * DATA_W;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_sof = 1'b0, pad_max = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic in_ready, out_valid, out_sof, out_eof;
  logic [WW-1:0] out_window;

  always #5 clk = ~clk;

  window_gen_kxk #(.DATA_W(DATA_W), .K(K), .IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sof     (in_sof),
    .in_data    (in_data),
    .pad_max    (pad_max),
    .out_valid  (out_valid),
    .out_window (out_window),
    .out_sof    (out_sof),
    .out_eof    (out_eof)
  );

  typedef struct {
    logic [WW-1:0] win;
    logic          sof;
    logic          eof;
  } exp_t;

  exp_t          exp_q[$];
  logic [WW-1:0] log_w[$];
  logic          log_sof[$];
  logic          log_eof[$];
  logic [WW-1:0] ref_log[$];
  int  checks = 0, errors = 0, cyc = 0, first_out_cyc = -1, sof_cyc = 0;
  bit  run_phase = 1'b0;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  function automatic logic [WW-1:0] model_win(input int f[N], input bit pad, input int cx, input int cy);
    logic [WW-1:0] w;
    int yy, xx, v;
    w = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) begin
        yy = cy - R + r;
        xx = cx - R + c;
        if (yy < 0 || yy >= H || xx < 0 || xx >= W) v = pad ? 255 : 0;
        else v = f[yy * W + xx];
        w[(r * K + c) * DATA_W +: DATA_W] = v[DATA_W-1:0];
      end
    return w;
  endfunction

  function automatic logic [WW-1:0] lit(input int e[K*K]);
    logic [WW-1:0] w;
    w = '0;
    for (int j = 0; j < K * K; j++) w[j * DATA_W +: DATA_W] = e[j][DATA_W-1:0];
    return w;
  endfunction

  task automatic chk(input string name, input logic [WW-1:0] got, input logic [WW-1:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic check_outputs();
    exp_t e;
    if (run_phase && !in_valid) begin
      checks++;
      if (out_valid) begin
        errors++;
        $display("FAIL gap_out: out_valid=1 after a gap cycle, required 0");
      end
    end
    if (out_valid) begin
      log_w.push_back(out_window);
      log_sof.push_back(out_sof);
      log_eof.push_back(out_eof);
      if (first_out_cyc < 0) first_out_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: window %h with no window pending", out_window);
      end else begin
        e = exp_q.pop_front();
        if (out_window !== e.win || out_sof !== e.sof || out_eof !== e.eof) begin
          errors++;
          $display("FAIL window: got %h sof=%b eof=%b, required %h sof=%b eof=%b",
                   out_window, out_sof, out_eof, e.win, e.sof, e.eof);
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  task automatic clear_logs();
    log_w.delete();
    log_sof.delete();
    log_eof.delete();
    first_out_cyc = -1;
  endtask

  // kind 0: ramp base+y*W+x+1; kind 1: random pixels. abort_at>=0 sends only that many beats.
  task automatic send_frame(input int kind, input int base, input bit pad, input int gap_pct, input int abort_at);
    int   f[N];
    int   nbeats, nexp, g;
    exp_t e;
    for (int i = 0; i < N; i++) f[i] = kind ? int'($urandom_range(0, 255)) : base + i + 1;
    nbeats = (abort_at < 0) ? N : abort_at;
    nexp   = (abort_at < 0) ? N : ((abort_at > D) ? abort_at - D : 0);
    for (int n = 0; n < nexp; n++) begin
      e.win = model_win(f, pad, n % W, n / W);
      e.sof = (n == 0);
      e.eof = (n == N - 1);
      exp_q.push_back(e);
    end
    for (int i = 0; i < nbeats; i++) begin
      g = 0;
      while (i > 0 && g < 20 && int'($urandom_range(0, 99)) < gap_pct) begin
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = DATA_W'($urandom);
        g++;
        step();
      end
      in_valid = 1'b1;
      in_sof   = (i == 0);
      in_data  = f[i][DATA_W-1:0];
      pad_max  = (i == 0) ? pad : ~pad;
      if (i == 0) begin
        run_phase = 1'b1;
        sof_cyc   = cyc;
      end
      step();
    end
    if (abort_at < 0) run_phase = 1'b0;
  endtask

  task automatic do_flush();
    int low;
    low = 0;
    while (!in_ready && low < 20) begin
      low++;
      in_valid = 1'b1;
      in_sof   = 1'b1;
      in_data  = DATA_W'($urandom);
      step();
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    chk("flush_len", WW'(low), WW'(D));
    chk("ready_after_flush", WW'(in_ready), WW'(1));
    for (int i = 0; i < 4; i++) step();
  endtask

  initial begin
    int t[K*K];

    step();
    step();
    chk("rst_out_valid", WW'(out_valid), '0);
    chk("rst_out_window", out_window, '0);
    chk("rst_sof_eof", WW'({out_sof, out_eof}), '0);
    chk("rst_in_ready", WW'(in_ready), WW'(1));
    rst = 1'b0;

    // beats without sof in IDLE are dropped
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_sof   = 1'b0;
      in_data  = DATA_W'($urandom);
      step();
    end
    in_valid = 1'b0;
    step();

    // case 1: zero pad, continuous
    clear_logs();
    send_frame(0, 0, 1'b0, 0, -1);
    do_flush();
    chk("c1_count", WW'(log_w.size()), WW'(N));
    chk("c1_latency", WW'(first_out_cyc - sof_cyc), WW'(D + 1));
    if (log_w.size() == N) begin
      t = '{0, 0, 0, 0, 1, 2, 0, 5, 6};
      chk("c1_win00", log_w[0], lit(t));
      chk("c1_sof", WW'(log_sof[0]), WW'(1));
      t = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
      chk("c1_win11", log_w[5], lit(t));
    end
    ref_log = log_w;

    // case 2: max pad
    clear_logs();
    send_frame(0, 0, 1'b1, 0, -1);
    do_flush();
    chk("c2_count", WW'(log_w.size()), WW'(N));
    if (log_w.size() == N) begin
      t = '{11, 12, 255, 15, 16, 255, 255, 255, 255};
      chk("c2_win33", log_w[N-1], lit(t));
      chk("c2_eof", WW'(log_eof[N-1]), WW'(1));
    end

    // case 4: ~50% gaps, same frame as case 1
    clear_logs();
    send_frame(0, 0, 1'b0, 50, -1);
    do_flush();
    chk("c4_count", WW'(log_w.size()), WW'(N));
    if (log_w.size() == N && ref_log.size() == N)
      for (int i = 0; i < N; i++) chk("c4_same_as_c1", log_w[i], ref_log[i]);

    // case 5: restart on input beat 7 with a +100 ramp
    clear_logs();
    send_frame(0, 0, 1'b0, 0, 7);
    send_frame(0, 100, 1'b0, 0, -1);
    do_flush();
    chk("c5_count", WW'(log_w.size()), WW'(D - D + 7 - D + N));
    if (log_w.size() == 7 - D + N) begin
      t = '{0, 0, 0, 0, 101, 102, 0, 105, 106};
      chk("c5_first_new", log_w[7 - D], lit(t));
      chk("c5_sof", WW'(log_sof[7 - D]), WW'(1));
    end

    // case 6: reset in the middle of FLUSH
    send_frame(0, 0, 1'b0, 0, -1);
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    chk("c6_no_out", WW'(out_valid), '0);
    chk("c6_ready", WW'(in_ready), WW'(1));
    exp_q.delete();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_sof   = 1'b0;
      in_data  = DATA_W'($urandom);
      step();
    end
    clear_logs();
    send_frame(1, 0, 1'($urandom_range(0, 1)), 30, -1);
    do_flush();
    chk("c6_count", WW'(log_w.size()), WW'(N));

    // extra random frames
    for (int k = 0; k < 3; k++) begin
      clear_logs();
      send_frame(1, 0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 60)), -1);
      do_flush();
      chk("rand_count", WW'(log_w.size()), WW'(N));
    end
    chk("queue_empty", WW'(exp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
